// File: rtl/mipmap_stream_loader_pkg.sv
// Shared definitions for the mipmap stream loader.
//   load_state_e  : loader FSM state encoding
//   next_lod_exp  : log2 size of the following LOD, clamped at one word
//   upper_base    : first word address of the upper (LOD1..n) region
package mipmap_stream_loader_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StDrain = 2'd2
    } load_state_e;

    // Each LOD is a quarter of the previous one; the tail LOD is a single word.
    function automatic int unsigned next_lod_exp(input int unsigned exp_cur);
        return (exp_cur >= 2) ? exp_cur - 2 : 0;
    endfunction

    function automatic int unsigned upper_base(input int unsigned addr_width);
        return 32'd1 << (addr_width - 1);
    endfunction

endpackage

// File: rtl/mipmap_lod_addr_gen.sv
// Address generator for the mipmap stream loader.
// Tracks the current LOD (level), the word offset inside it and the LOD base address.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   restart_i       latch size/mipmap config, rewind to LOD0 word 0
//   size_log2_i     log2 of LOD0 size in words
//   mipmap_i        1: all LODs, 0: LOD0 only
//   advance_i       step to the next word (one accepted beat)
//   addr_o          RAM address of the current word
//   final_o         current word is the last word of the last LOD
module mipmap_lod_addr_gen
    import mipmap_stream_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned SIZE_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  restart_i,
    input  logic [SIZE_WIDTH-1:0] size_log2_i,
    input  logic                  mipmap_i,
    input  logic                  advance_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  final_o
);

    localparam logic [ADDR_WIDTH-1:0] UpperBase = ADDR_WIDTH'(upper_base(ADDR_WIDTH));

    logic [SIZE_WIDTH-1:0] exp_q, exp_d;
    logic [SIZE_WIDTH-1:0] level_q, level_d;
    logic                  mip_q, mip_d;
    logic [ADDR_WIDTH-2:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;

    logic [ADDR_WIDTH-1:0] lod_size;
    logic [ADDR_WIDTH-1:0] word_max;
    logic                  word_end;
    logic                  last_lod;

    always_comb begin
        lod_size = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << exp_q;
        word_max = lod_size - ADDR_WIDTH'(1);
        word_end = ({1'b0, word_q} == word_max);
        // exp_q is clamped at 0, so exp_q == 0 covers both s-2k == 0 and s-2k < 0.
        last_lod = !mip_q || (exp_q == '0);
        final_o  = last_lod && word_end;
        addr_o   = base_q + {1'b0, word_q};

        exp_d   = exp_q;
        level_d = level_q;
        mip_d   = mip_q;
        word_d  = word_q;
        base_d  = base_q;

        if (restart_i) begin
            exp_d   = size_log2_i;
            mip_d   = mipmap_i;
            level_d = '0;
            word_d  = '0;
            base_d  = '0;
        end else if (advance_i) begin
            if (word_end) begin
                word_d  = '0;
                level_d = level_q + SIZE_WIDTH'(1);
                exp_d   = SIZE_WIDTH'(next_lod_exp(32'(exp_q)));
                // LOD1 starts the upper region; later LODs pack behind their predecessor.
                base_d  = (level_q == '0) ? UpperBase : base_q + lod_size;
            end else begin
                word_d = word_q + (ADDR_WIDTH-1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            exp_q   <= '0;
            level_q <= '0;
            mip_q   <= 1'b0;
            word_q  <= '0;
            base_q  <= '0;
        end else begin
            exp_q   <= exp_d;
            level_q <= level_d;
            mip_q   <= mip_d;
            word_q  <= word_d;
            base_q  <= base_d;
        end
    end

endmodule

// File: rtl/mipmap_stream_loader.sv
// Write sequencer for the mipmap texture RAM. Consumes a texture stream (LOD0 first, then
// the smaller LODs) and writes each word to RAM: LOD0 in the lower half, LOD1..n packed
// back-to-back from the start of the upper half.
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   cfgSizeLog2, cfgMipmap, start    load configuration and request (sampled at start)
//   busy, done                       load/drain in progress, one-cycle end pulse
//   errLast, errCfg                  sticky misplaced-tlast and bad-size flags
//   s_axis_*                         texel stream slave
//   ramWrite*                        RAM write port, one cycle after each accepted beat
module mipmap_stream_loader
    import mipmap_stream_loader_pkg::*;
#(
    parameter int unsigned MEM_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MASK_WIDTH = 8,
    parameter int unsigned SIZE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [SIZE_WIDTH-1:0] cfgSizeLog2,
    input  logic                  cfgMipmap,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  errLast,
    output logic                  errCfg,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [MEM_WIDTH-1:0]  s_axis_tdata,
    output logic                  ramWrite,
    output logic [ADDR_WIDTH-1:0] ramWriteAddr,
    output logic [MEM_WIDTH-1:0]  ramWriteData,
    output logic [MASK_WIDTH-1:0] ramWriteMask
);

    load_state_e           state_q, state_d;
    logic                  done_q, done_d;
    logic                  err_last_q, err_last_d;
    logic                  err_cfg_q, err_cfg_d;
    logic                  ram_write_q, ram_write_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [MEM_WIDTH-1:0]  ram_data_q, ram_data_d;

    logic                  gen_restart;
    logic                  gen_advance;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  gen_final;
    logic                  beat;
    logic                  cfg_bad;

    mipmap_lod_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SIZE_WIDTH (SIZE_WIDTH)
    ) u_addr_gen (
        .clk_i       (clk),
        .rst_ni      (resetn),
        .restart_i   (gen_restart),
        .size_log2_i (cfgSizeLog2),
        .mipmap_i    (cfgMipmap),
        .advance_i   (gen_advance),
        .addr_o      (gen_addr),
        .final_o     (gen_final)
    );

    assign busy          = (state_q != StIdle);
    assign s_axis_tready = busy;
    assign beat          = s_axis_tvalid && s_axis_tready;
    assign cfg_bad       = 32'(cfgSizeLog2) > (ADDR_WIDTH - 1);

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        err_last_d  = err_last_q;
        err_cfg_d   = err_cfg_q;
        ram_write_d = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        gen_restart = 1'b0;
        gen_advance = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_cfg_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        err_last_d  = 1'b0;
                        gen_restart = 1'b1;
                        state_d     = StLoad;
                    end
                end
            end
            StLoad: begin
                if (beat) begin
                    ram_write_d = 1'b1;
                    ram_addr_d  = gen_addr;
                    ram_data_d  = s_axis_tdata;
                    gen_advance = 1'b1;
                    if (gen_final) begin
                        if (s_axis_tlast) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            // Stream is longer than the texture: swallow the excess.
                            err_last_d = 1'b1;
                            state_d    = StDrain;
                        end
                    end else if (s_axis_tlast) begin
                        err_last_d = 1'b1;
                        state_d    = StIdle;
                        done_d     = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (beat && s_axis_tlast) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            done_q      <= 1'b0;
            err_last_q  <= 1'b0;
            err_cfg_q   <= 1'b0;
            ram_write_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            err_last_q  <= err_last_d;
            err_cfg_q   <= err_cfg_d;
            ram_write_q <= ram_write_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
        end
    end

    assign done         = done_q;
    assign errLast      = err_last_q;
    assign errCfg       = err_cfg_q;
    assign ramWrite     = ram_write_q;
    assign ramWriteAddr = ram_addr_q;
    assign ramWriteData = ram_data_q;
    assign ramWriteMask = '1;

endmodule
